paddle_input_ctrl: RTL and testbench
====================================

// Module: paddle_input_ctrl
// PURPOSE
//  Conditions one player's raw up/down push-buttons into the 2-bit move code that the paddle
//  position stage consumes (1 = move down, +DY; 2 = move up, -DY; 0 = hold). Synchronises,
//  debounces, resolves conflicts, and rate-limits movement to single-cycle step pulses with
//  hold-to-repeat. One instance per player, placed directly ahead of that player's paddle.
// PARAMETERS
//  DEBOUNCE_CYCLES  250000  consecutive stable cycles needed to accept a new level (>=2)
//  REPEAT_DELAY     6250000 cycles from first step pulse to second while held (>=2)
//  REPEAT_PERIOD    416667  cycles between subsequent step pulses while held (>=2)
// PORTS
//  clk         in   1  system clock
//  rst         in   1  reset, synchronous, active-high
//  btn_up_raw  in   1  asynchronous raw "up" button, active-high
//  btn_dn_raw  in   1  asynchronous raw "down" button, active-high
//  enable      in   1  game running; 0 suppresses all step pulses
//  btn         out  2  registered move code to paddle: 0 none, 1 down, 2 up; never 3
//  up_held     out  1  debounced up level
//  dn_held     out  1  debounced down level
// BEHAVIOUR
//  Reset: sync flops, debounce counters, up_held, dn_held, btn = 0; FSM -> IDLE; timer = 0.
//  Sync: 2-flop synchroniser per button; no logic between the two flops.
//  Debounce (per button): counter clears on any cycle where synced == held; otherwise it
//   increments. On the edge where the counter == DEBOUNCE_CYCLES-1 and still differs,
//   held <= synced and counter <= 0. Glitches shorter than DEBOUNCE_CYCLES never propagate.
//  Direction: dir = DN if dn_held & !up_held; UP if up_held & !dn_held; NONE otherwise
//   (both pressed = NONE).
//  FSM states IDLE, DELAY, REPEAT; down-counting timer, width $clog2 of max(DELAY, PERIOD)+1.
//   IDLE:   if enable & dir!=NONE -> btn <= code(dir), latch dir, timer <= REPEAT_DELAY-1, -> DELAY.
//   DELAY:  timer decrements; at timer==0 -> emit pulse, timer <= REPEAT_PERIOD-1, -> REPEAT.
//   REPEAT: timer decrements; at timer==0 -> emit pulse, reload REPEAT_PERIOD-1.
//   Any state: !enable or dir==NONE -> IDLE, btn <= 0 that edge (no pulse).
//   DELAY/REPEAT: dir differs from latched dir -> behave as IDLE entry with new dir
//    (immediate pulse, restart DELAY).
//  btn high for exactly one cycle per step; 0 on every other cycle.
//  Pulse spacing while held: first at t0, second at t0+REPEAT_DELAY, then every REPEAT_PERIOD.
//  Latency: raw edge first sampled at edge E0 -> held updates at E0+DEBOUNCE_CYCLES+1 ->
//   first btn pulse visible after edge E0+DEBOUNCE_CYCLES+2.
//  Debounce keeps running while enable=0; enable rising with a button held -> pulse next edge.
//  rst mid-operation: all state cleared on that edge; pulse in flight dropped.
// TESTING  (DEBOUNCE_CYCLES=4, REPEAT_DELAY=10, REPEAT_PERIOD=3)
//  1 rst 3 cycles, then idle -> btn=0, up_held=dn_held=0 throughout.
//  2 dn_raw 0->1 sampled at E0, enable=1, held 30 cycles -> dn_held=1 after E0+5; btn=1 single
//    cycle after E0+6, then after E0+16, E0+19, E0+22, ...; btn=0 on all other cycles.
//  3 up_raw 3-cycle glitch -> up_held stays 0, btn stays 0; 4-cycle pulse -> up_held=1, one btn=2.
//  4 both raw held -> btn=0 always; release down -> btn=2 pulse next edge after dn_held falls.
//  5 up held in REPEAT, switch to down (overlap) -> btn=1 immediately on dir change, 10-cycle
//    gap to next.
//  6 enable=0 while held -> no pulses; enable->1 -> btn=2 next edge; rst mid-DELAY -> all zeros.

Source files
------------

// File: rtl/paddle_input_ctrl.sv
// Per-player paddle input conditioning: synchroniser, debouncer, direction resolve,
// and single-cycle step pulses with hold-to-repeat timing.
module paddle_input_ctrl #(
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int REPEAT_DELAY    = 6250000,
  parameter int REPEAT_PERIOD   = 416667
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_up_raw,
  input  logic       btn_dn_raw,
  input  logic       enable,
  output logic [1:0] btn,
  output logic       up_held,
  output logic       dn_held
);

  localparam int CW   = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int TMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int TW   = $clog2(TMAX + 1);

  localparam logic [CW-1:0] CNT_LAST      = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [TW-1:0] DELAY_RELOAD  = TW'(REPEAT_DELAY - 1);
  localparam logic [TW-1:0] PERIOD_RELOAD = TW'(REPEAT_PERIOD - 1);

  localparam logic [1:0] MV_NONE = 2'd0;
  localparam logic [1:0] MV_DN   = 2'd1;
  localparam logic [1:0] MV_UP   = 2'd2;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_DELAY  = 2'd1;
  localparam logic [1:0] S_REPEAT = 2'd2;

  // Bit 0 = up, bit 1 = down throughout.
  logic [1:0]    r_sync1;
  logic [1:0]    r_sync2;
  logic [1:0]    r_held;
  logic [CW-1:0] r_cnt [2];

  logic [1:0]    r_state;
  logic [1:0]    r_dir;
  logic [1:0]    r_btn;
  logic [TW-1:0] r_timer;
  logic [1:0]    w_dir;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= {btn_dn_raw, btn_up_raw};
      r_sync2 <= r_sync1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_held <= '0;
      for (int unsigned i = 0; i < 2; i++) r_cnt[i] <= '0;
    end else begin
      for (int unsigned i = 0; i < 2; i++) begin
        if (r_sync2[i] == r_held[i]) begin
          r_cnt[i] <= '0;
        end else if (r_cnt[i] == CNT_LAST) begin
          r_held[i] <= r_sync2[i];
          r_cnt[i]  <= '0;
        end else begin
          r_cnt[i] <= r_cnt[i] + 1'b1;
        end
      end
    end
  end

  always_comb begin
    w_dir = MV_NONE;
    if (r_held[1] && !r_held[0])      w_dir = MV_DN;
    else if (r_held[0] && !r_held[1]) w_dir = MV_UP;
  end

  // A direction change while stepping is handled exactly like a fresh press.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_dir   <= MV_NONE;
      r_btn   <= MV_NONE;
      r_timer <= '0;
    end else begin
      r_btn <= MV_NONE;
      if (!enable || w_dir == MV_NONE) begin
        r_state <= S_IDLE;
      end else if (r_state == S_IDLE || w_dir != r_dir) begin
        r_btn   <= w_dir;
        r_dir   <= w_dir;
        r_timer <= DELAY_RELOAD;
        r_state <= S_DELAY;
      end else if (r_timer == '0) begin
        r_btn   <= w_dir;
        r_timer <= PERIOD_RELOAD;
        r_state <= S_REPEAT;
      end else begin
        r_timer <= r_timer - 1'b1;
      end
    end
  end

  assign btn     = r_btn;
  assign up_held = r_held[0];
  assign dn_held = r_held[1];

endmodule

// File: tb/tb_paddle_input_ctrl.sv
// Bench for paddle_input_ctrl: timing-rule model checked every cycle, plus directed
// literal expectations at the key pulse times.
module tb_paddle_input_ctrl;

  localparam int DEB = 4;
  localparam int RD  = 10;
  localparam int RP  = 3;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       up_raw = 1'b0;
  logic       dn_raw = 1'b0;
  logic       enable = 1'b0;
  logic [1:0] btn;
  logic       up_held;
  logic       dn_held;

  int checks = 0;
  int errors = 0;

  paddle_input_ctrl #(
    .DEBOUNCE_CYCLES(DEB),
    .REPEAT_DELAY   (RD),
    .REPEAT_PERIOD  (RP)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .btn_up_raw(up_raw),
    .btn_dn_raw(dn_raw),
    .enable    (enable),
    .btn       (btn),
    .up_held   (up_held),
    .dn_held   (dn_held)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model: held flips once the last DEB synced samples all disagree with it; steps
  // fire at t0, t0+RD, t0+RD+k*RP where t0 is when the effective direction last changed.
  logic [1:0] m_s1, m_s2, m_held;
  logic [1:0] m_hist [DEB];
  int         m_btn = 0;
  int         m_prev_eff = 0;
  int         m_t0 = 0;
  int         m_edge = 0;
  bit         m_valid = 0;

  initial forever begin
    @(posedge clk);
    if (rst) begin
      m_s1 = '0; m_s2 = '0; m_held = '0;
      for (int i = 0; i < DEB; i++) m_hist[i] = '0;
      m_btn = 0; m_prev_eff = 0;
      m_valid = 1;
    end else begin
      int eff;
      int d;
      bit all_diff;
      eff = 0;
      if (enable && (m_held[0] != m_held[1])) eff = m_held[1] ? 1 : 2;
      if (eff != 0 && eff != m_prev_eff) m_t0 = m_edge;
      m_btn = 0;
      if (eff != 0) begin
        d = m_edge - m_t0;
        if (d == 0 || (d >= RD && (d - RD) % RP == 0)) m_btn = eff;
      end
      m_prev_eff = eff;
      for (int i = DEB - 1; i > 0; i--) m_hist[i] = m_hist[i-1];
      m_hist[0] = m_s2;
      for (int b = 0; b < 2; b++) begin
        all_diff = 1;
        for (int i = 0; i < DEB; i++) if (m_hist[i][b] == m_held[b]) all_diff = 0;
        if (all_diff) m_held[b] = ~m_held[b];
      end
      m_s2 = m_s1;
      m_s1 = {dn_raw, up_raw};
    end
    m_edge++;
  end

  initial forever begin
    @(negedge clk);
    if (m_valid) begin
      chk("model_btn", int'(btn), m_btn);
      chk("model_up_held", int'(up_held), int'(m_held[0]));
      chk("model_dn_held", int'(dn_held), int'(m_held[1]));
    end
  end

  int rec [32];
  int hd  [32];
  int n;

  task automatic capture(input int len);
    for (int j = 0; j < len; j++) begin
      @(negedge clk);
      rec[j] = int'(btn);
      hd[j]  = int'(dn_held);
    end
  endtask

  initial begin
    // 1: reset then idle
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    chk("idle_btn", int'(btn), 0);
    chk("idle_up_held", int'(up_held), 0);
    enable = 1'b1;

    // 2: down press, repeat timing
    dn_raw = 1'b1;
    capture(30);
    chk("dn_held_pre", hd[4], 0);
    chk("dn_held_rise", hd[5], 1);
    chk("dn_first_pre", rec[5], 0);
    chk("dn_first", rec[6], 1);
    chk("dn_after_first", rec[7], 0);
    chk("dn_delay_end_pre", rec[15], 0);
    chk("dn_second", rec[16], 1);
    chk("dn_gap", rec[18], 0);
    chk("dn_third", rec[19], 1);
    chk("dn_fourth", rec[22], 1);
    n = 0;
    for (int j = 0; j < 30; j++) if (rec[j] != 0) n++;
    chk("dn_pulse_count", n, 6);
    dn_raw = 1'b0;
    repeat (20) @(negedge clk);

    // 3: glitch rejected, minimal press accepted
    up_raw = 1'b1;
    repeat (3) @(negedge clk);
    up_raw = 1'b0;
    repeat (10) @(negedge clk);
    chk("glitch_up_held", int'(up_held), 0);
    n = 0;
    up_raw = 1'b1;
    for (int j = 0; j < 4; j++) begin @(negedge clk); if (btn == 2'd2) n++; end
    up_raw = 1'b0;
    for (int j = 0; j < 16; j++) begin @(negedge clk); if (btn == 2'd2) n++; end
    chk("short_press_pulses", n, 1);

    // 4: both pressed -> nothing; release down -> up pulse
    up_raw = 1'b1;
    dn_raw = 1'b1;
    n = 0;
    for (int j = 0; j < 20; j++) begin @(negedge clk); if (btn != 2'd0) n++; end
    chk("both_pulses", n, 0);
    dn_raw = 1'b0;
    capture(10);
    chk("release_pre", rec[5], 0);
    chk("release_pulse", rec[6], 2);

    // 5: up repeating, direct swap to down
    repeat (12) @(negedge clk);
    up_raw = 1'b0;
    dn_raw = 1'b1;
    capture(20);
    chk("swap_pulse", rec[6], 1);
    n = 0;
    for (int j = 7; j < 16; j++) if (rec[j] != 0) n++;
    chk("swap_gap", n, 0);
    chk("swap_second", rec[16], 1);

    // 6: enable gating, then reset mid-DELAY
    enable = 1'b0;
    dn_raw = 1'b0;
    up_raw = 1'b1;
    n = 0;
    for (int j = 0; j < 15; j++) begin @(negedge clk); if (btn != 2'd0) n++; end
    chk("disabled_pulses", n, 0);
    chk("disabled_up_held", int'(up_held), 1);
    enable = 1'b1;
    @(negedge clk);
    chk("enable_pulse", int'(btn), 2);
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("rst_btn", int'(btn), 0);
    chk("rst_up_held", int'(up_held), 0);
    chk("rst_dn_held", int'(dn_held), 0);
    rst = 1'b0;
    up_raw = 1'b0;
    repeat (10) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
